// File: rtl/exe_pkg.sv
// Shared execution-engine definitions: bus unit selects, opcodes and ALU state types.
// The engine and every ALU slave import this package instead of redefining the constants.
package exe_pkg;

    localparam int BUS_W = 256;

    localparam logic [3:0] MainMemEn    = 4'd1;
    localparam logic [3:0] MatrixAluEn  = 4'd2;
    localparam logic [3:0] IntegerAluEn = 4'd3;
    localparam logic [3:0] ExecuteEn    = 4'd4;

    localparam logic [7:0] MMult1     = 8'h00;
    localparam logic [7:0] MAdd       = 8'h01;
    localparam logic [7:0] MSub       = 8'h02;
    localparam logic [7:0] MTranspose = 8'h03;
    localparam logic [7:0] MScale     = 8'h04;
    localparam logic [7:0] MScaleImm  = 8'h05;
    localparam logic [7:0] IntAdd     = 8'h10;
    localparam logic [7:0] IntSub     = 8'h11;
    localparam logic [7:0] IntMult    = 8'h12;
    localparam logic [7:0] IntDiv     = 8'h13;
    localparam logic [7:0] STOP       = 8'hFF;

    typedef enum logic [1:0] {IDLE, CALC, DONE} alu_state_t;
    typedef enum logic {MD_MULT, MD_DIV} md_mode_t;

    function automatic logic is_muldiv(input logic [7:0] op);
        return (op == IntMult) || (op == IntDiv);
    endfunction

endpackage

// File: rtl/integer_alu_if.sv
// Execution-engine shared bus as seen by one ALU slave.
// The engine drives address/opcode/strobes/data; the slave returns result and status.
interface integer_alu_if;
    import exe_pkg::*;

    logic [15:0]      address;
    logic [7:0]       opcode;
    logic             nRead;
    logic             nWrite;
    logic [BUS_W-1:0] ExeDataOut;
    logic [BUS_W-1:0] IntDataOut;
    logic             IntBusy;
    logic             IntDivZero;

    modport master (
        output address, opcode, nRead, nWrite, ExeDataOut,
        input  IntDataOut, IntBusy, IntDivZero
    );

    modport slave (
        input  address, opcode, nRead, nWrite, ExeDataOut,
        output IntDataOut, IntBusy, IntDivZero
    );

endinterface

// File: rtl/int_seq_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per clock.
// done_o marks the cycle whose step is the last; result_o already includes that step.
module int_seq_muldiv
    import exe_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  md_mode_t          mode_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              divzero_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic              active_q;
    md_mode_t          mode_q;
    logic              dz_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] x_q, y_q, acc_q;
    logic [DATA_W-1:0] x_d, y_d, acc_d;
    logic [DATA_W:0]   rem_sh, trial;

    // Multiply: x = shifted multiplicand, y = multiplier, acc = product.
    // Divide:   x = divisor, y = dividend shifting out / quotient shifting in, acc = remainder.
    always_comb begin
        rem_sh = {acc_q, y_q[DATA_W-1]};
        trial  = rem_sh - {1'b0, x_q};
        if (mode_q == MD_MULT) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
        end else begin
            acc_d = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
            x_d   = x_q;
            y_d   = {y_q[DATA_W-2:0], ~trial[DATA_W]};
        end
    end

    assign done_o    = active_q && (dz_q || (cnt_q == LAST));
    assign divzero_o = dz_q;
    assign result_o  = dz_q ? '1 : ((mode_q == MD_MULT) ? acc_d : y_d);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            mode_q   <= MD_MULT;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            mode_q   <= mode_i;
            dz_q     <= (mode_i == MD_DIV) && (b_i == '0);
            cnt_q    <= '0;
            x_q      <= (mode_i == MD_DIV) ? b_i : a_i;
            y_q      <= (mode_i == MD_DIV) ? a_i : b_i;
            acc_q    <= '0;
        end else if (active_q) begin
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/integer_alu.sv
// Integer ALU bus slave: decode, operand capture, single-cycle add/sub and the
// IDLE/CALC/DONE sequencer; mult/div are delegated to int_seq_muldiv.
module integer_alu
    import exe_pkg::*;
#(
    parameter int         DATA_W  = 64,
    parameter logic [3:0] UNIT_ID = IntegerAluEn
) (
    input  logic          Clk,
    input  logic          nReset,
    integer_alu_if.slave  bus
);

    alu_state_t        state_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, out_q;
    logic [7:0]        op_q;
    logic              busy_q, divzero_q, dz_pend_q;

    logic              sel, accept;
    logic [DATA_W-1:0] src1, src2, addsub_d;
    logic              md_start, md_done, md_divzero;
    md_mode_t          md_mode;
    logic [DATA_W-1:0] md_result;
    logic              unused_bus;

    function automatic logic [DATA_W-1:0] alu_addsub(input logic [7:0] op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        case (op)
            IntAdd:  return a + b;
            IntSub:  return a - b;
            default: return '0;
        endcase
    endfunction

    assign sel      = (bus.address[15:12] == UNIT_ID);
    assign accept   = sel && !bus.nWrite && (state_q == IDLE);
    assign src1     = bus.ExeDataOut[DATA_W-1:0];
    assign src2     = bus.ExeDataOut[2*DATA_W-1:DATA_W];
    assign addsub_d = alu_addsub(op_q, a_q, b_q);

    // The sequencer starts on the same edge that captures the operands.
    assign md_start = accept && is_muldiv(bus.opcode);
    assign md_mode  = (bus.opcode == IntDiv) ? MD_DIV : MD_MULT;

    // Reads carry no side effects; these bus bits are never looked at.
    assign unused_bus = ^{bus.nRead, bus.address[11:0], bus.ExeDataOut[BUS_W-1:2*DATA_W]};

    int_seq_muldiv #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk_i     (Clk),
        .rst_ni    (nReset),
        .start_i   (md_start),
        .mode_i    (md_mode),
        .a_i       (src1),
        .b_i       (src2),
        .done_o    (md_done),
        .result_o  (md_result),
        .divzero_o (md_divzero)
    );

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            dz_pend_q <= 1'b0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= src1;
                        b_q     <= src2;
                        op_q    <= bus.opcode;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (!is_muldiv(op_q)) begin
                        res_q     <= addsub_d;
                        dz_pend_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (md_done) begin
                        res_q     <= md_result;
                        dz_pend_q <= md_divzero;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    out_q     <= res_q;
                    divzero_q <= dz_pend_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.IntDataOut = {{(BUS_W-DATA_W){1'b0}}, out_q};
    assign bus.IntBusy    = busy_q;
    assign bus.IntDivZero = divzero_q;

endmodule

// File: tb/tb_integer_alu.sv
// Self-checking bench for integer_alu: directed and random ops against plain arithmetic.
module tb_integer_alu;
    import exe_pkg::*;

    logic clk = 1'b0;
    logic nreset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    integer_alu_if bus();

    integer_alu #(.DATA_W(64), .UNIT_ID(IntegerAluEn)) dut (
        .Clk    (clk),
        .nReset (nreset),
        .bus    (bus.slave)
    );

    // Called at a negedge; the write is sampled on the next posedge (edge N).
    // lat = k where IntBusy is first seen low after edge N+k, -1 on timeout.
    task automatic run_op(input logic [3:0] unit, input logic [7:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          output int lat, output logic busy1);
        bus.address    = {unit, 12'h5A5};
        bus.opcode     = op;
        bus.ExeDataOut = {$urandom, $urandom, $urandom, $urandom, b, a};
        bus.nWrite     = 1'b0;
        bus.nRead      = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.nWrite = 1'b1;
        bus.nRead  = 1'b1;
        busy1 = bus.IntBusy;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!bus.IntBusy) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.IntBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.IntBusy); end
        checks++; if (bus.IntDataOut !== 256'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.IntDataOut); end
        checks++; if (bus.IntDivZero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", bus.IntDivZero); end
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic b1;
        run_op(IntegerAluEn, IntAdd, 64'd5, 64'd7, lat, b1);
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", b1); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_lat got=%0d exp=2", lat); end
        checks++; if (bus.IntDataOut !== 256'd12) begin failures++; $display("FAIL add_data got=%h exp=12", bus.IntDataOut); end
        checks++; if (bus.IntDivZero !== 1'b0) begin failures++; $display("FAIL add_dz got=%b exp=0", bus.IntDivZero); end
    endtask

    task automatic test_sub_wrap();
        int lat; logic b1;
        run_op(IntegerAluEn, IntSub, 64'd3, 64'd5, lat, b1);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sub_lat got=%0d exp=2", lat); end
        checks++; if (bus.IntDataOut !== {192'h0, 64'hFFFF_FFFF_FFFF_FFFE}) begin failures++; $display("FAIL sub_wrap got=%h", bus.IntDataOut); end
    endtask

    task automatic test_addsub_random();
        int lat; logic b1; logic [63:0] a, b, exp; logic [7:0] op;
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            op = ($urandom_range(0, 1) == 1) ? IntSub : IntAdd;
            exp = (op == IntAdd) ? a + b : a - b;
            run_op(IntegerAluEn, op, a, b, lat, b1);
            checks++; if (lat !== 2) begin failures++; $display("FAIL rnd_addsub_lat[%0d] got=%0d exp=2", i, lat); end
            checks++; if (bus.IntDataOut !== {192'h0, exp}) begin failures++; $display("FAIL rnd_addsub[%0d] got=%h exp=%h", i, bus.IntDataOut, exp); end
        end
    endtask

    task automatic test_mult_ignore_write();
        int lat; logic b1;
        bus.address    = {IntegerAluEn, 12'h000};
        bus.opcode     = IntMult;
        bus.ExeDataOut = {128'h0, 64'h3, 64'h1_0000_0001};
        bus.nWrite     = 1'b0;
        @(negedge clk);
        bus.nWrite = 1'b1;
        b1 = bus.IntBusy;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 9) begin
                bus.opcode     = IntAdd;
                bus.ExeDataOut = {128'h0, 64'd9, 64'd9};
                bus.nWrite     = 1'b0;
            end
            if (k == 10) bus.nWrite = 1'b1;
            if (!bus.IntBusy) begin
                lat = k;
                break;
            end
        end
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL mult_busy got=%b exp=1", b1); end
        checks++; if (lat !== 65) begin failures++; $display("FAIL mult_lat got=%0d exp=65", lat); end
        checks++; if (bus.IntDataOut !== {192'h0, 64'h3_0000_0003}) begin failures++; $display("FAIL mult_data got=%h exp=300000003", bus.IntDataOut); end
        repeat (3) @(negedge clk);
        checks++; if (bus.IntBusy !== 1'b0) begin failures++; $display("FAIL mult_ignored_busy got=%b exp=0", bus.IntBusy); end
        checks++; if (bus.IntDataOut !== {192'h0, 64'h3_0000_0003}) begin failures++; $display("FAIL mult_ignored_data got=%h", bus.IntDataOut); end
    endtask

    task automatic test_muldiv_random();
        int lat; logic b1; logic [63:0] a, b, exp;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 2 == 0) begin
                exp = a * b;
                run_op(IntegerAluEn, IntMult, a, b, lat, b1);
            end else begin
                b = b >> $urandom_range(0, 62);
                if (b == 64'd0) b = 64'd1;
                exp = a / b;
                run_op(IntegerAluEn, IntDiv, a, b, lat, b1);
            end
            checks++; if (lat !== 65) begin failures++; $display("FAIL rnd_muldiv_lat[%0d] got=%0d exp=65", i, lat); end
            checks++; if (bus.IntDataOut !== {192'h0, exp}) begin failures++; $display("FAIL rnd_muldiv[%0d] got=%h exp=%h", i, bus.IntDataOut, exp); end
        end
    endtask

    task automatic test_div_divzero();
        int lat; logic b1;
        run_op(IntegerAluEn, IntDiv, 64'd100, 64'd7, lat, b1);
        checks++; if (lat !== 65) begin failures++; $display("FAIL div_lat got=%0d exp=65", lat); end
        checks++; if (bus.IntDataOut !== 256'd14) begin failures++; $display("FAIL div_data got=%h exp=14", bus.IntDataOut); end
        run_op(IntegerAluEn, IntDiv, 64'd1, 64'd0, lat, b1);
        checks++; if (lat !== 2) begin failures++; $display("FAIL dz_lat got=%0d exp=2", lat); end
        checks++; if (bus.IntDataOut !== {192'h0, {64{1'b1}}}) begin failures++; $display("FAIL dz_data got=%h", bus.IntDataOut); end
        checks++; if (bus.IntDivZero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", bus.IntDivZero); end
        run_op(IntegerAluEn, IntAdd, 64'd1, 64'd1, lat, b1);
        checks++; if (bus.IntDataOut !== 256'd2) begin failures++; $display("FAIL dz_clear_data got=%h exp=2", bus.IntDataOut); end
        checks++; if (bus.IntDivZero !== 1'b0) begin failures++; $display("FAIL dz_clear_flag got=%b exp=0", bus.IntDivZero); end
    endtask

    task automatic test_unknown_opcode();
        int lat; logic b1;
        run_op(IntegerAluEn, IntAdd, 64'd40, 64'd2, lat, b1);
        run_op(IntegerAluEn, MScaleImm, 64'd40, 64'd2, lat, b1);
        checks++; if (lat !== 2) begin failures++; $display("FAIL unk_lat got=%0d exp=2", lat); end
        checks++; if (bus.IntDataOut !== 256'h0) begin failures++; $display("FAIL unk_data got=%h exp=0", bus.IntDataOut); end
    endtask

    task automatic test_deselect();
        int lat; logic b1; logic seen_busy;
        run_op(IntegerAluEn, IntAdd, 64'd10, 64'd20, lat, b1);
        bus.address    = {MatrixAluEn, 12'h000};
        bus.opcode     = IntAdd;
        bus.ExeDataOut = {128'h0, 64'd1, 64'd2};
        bus.nWrite     = 1'b0;
        seen_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.nWrite = (k >= 1);
            if (bus.IntBusy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL desel_busy got=%b exp=0", seen_busy); end
        checks++; if (bus.IntDataOut !== 256'd30) begin failures++; $display("FAIL desel_data got=%h exp=30", bus.IntDataOut); end
    endtask

    task automatic test_reset_midop();
        int lat; logic b1;
        run_op(IntegerAluEn, IntDiv, 64'd5, 64'd0, lat, b1);
        bus.address    = {IntegerAluEn, 12'h000};
        bus.opcode     = IntMult;
        bus.ExeDataOut = {128'h0, 64'd6, 64'd7};
        bus.nWrite     = 1'b0;
        @(negedge clk);
        bus.nWrite = 1'b1;
        repeat (19) @(negedge clk);
        checks++; if (bus.IntBusy !== 1'b1) begin failures++; $display("FAIL midop_busy_before got=%b exp=1", bus.IntBusy); end
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        checks++; if (bus.IntBusy !== 1'b0) begin failures++; $display("FAIL midop_busy got=%b exp=0", bus.IntBusy); end
        checks++; if (bus.IntDataOut !== 256'h0) begin failures++; $display("FAIL midop_data got=%h exp=0", bus.IntDataOut); end
        checks++; if (bus.IntDivZero !== 1'b0) begin failures++; $display("FAIL midop_dz got=%b exp=0", bus.IntDivZero); end
        run_op(IntegerAluEn, IntAdd, 64'd2, 64'd2, lat, b1);
        checks++; if (lat !== 2) begin failures++; $display("FAIL midop_add_lat got=%0d exp=2", lat); end
        checks++; if (bus.IntDataOut !== 256'd4) begin failures++; $display("FAIL midop_add got=%h exp=4", bus.IntDataOut); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b1; logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        run_op(IntegerAluEn, IntAdd, a, b, lat, b1);
        checks++; if (bus.IntDataOut !== {192'h0, a + b}) begin failures++; $display("FAIL b2b_add got=%h", bus.IntDataOut); end
        run_op(IntegerAluEn, IntMult, a, b, lat, b1);
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL b2b_mult_accept got=%b exp=1", b1); end
        checks++; if (bus.IntDataOut !== {192'h0, a * b}) begin failures++; $display("FAIL b2b_mult got=%h", bus.IntDataOut); end
        run_op(IntegerAluEn, IntSub, a, b, lat, b1);
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL b2b_sub_accept got=%b exp=1", b1); end
        checks++; if (bus.IntDataOut !== {192'h0, a - b}) begin failures++; $display("FAIL b2b_sub got=%h", bus.IntDataOut); end
    endtask

    initial begin
        nreset         = 1'b0;
        bus.address    = 16'h0;
        bus.opcode     = 8'h0;
        bus.nRead      = 1'b1;
        bus.nWrite     = 1'b1;
        bus.ExeDataOut = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_wrap();
        test_addsub_random();
        test_mult_ignore_write();
        test_div_divzero();
        test_muldiv_random();
        test_unknown_opcode();
        test_deselect();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
